// File: rtl/eth_udp_pkg.sv
// Shared types and constants for the UDP payload streamer and its FIFO.
package eth_udp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEND,
        GAP
    } state_t;

    typedef enum logic {
        MODE_FIFO    = 1'b0,
        MODE_COUNTER = 1'b1
    } mode_t;

    localparam int SEQ_HDR_LEN = 2;

endpackage

// File: rtl/eth_udp_fifo.sv
// Synchronous FIFO of 2^DEPTH_LOG2 words; the head word is visible combinationally, zero when empty.
module eth_udp_fifo
    import eth_udp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  usr_clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  do_push, do_pop;

    assign full    = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; the pointers and level alone define which words are valid.
    always_ff @(posedge usr_clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/eth_udp_streamer.sv
// Packetises FIFO words (or a counter pattern) into bytes for a UDP PHY byte-strobe interface.
// Optional ETH_UDP_STREAMER_SEQNUM_EN prefixes each packet with a 16-bit sequence number.
module eth_udp_streamer
    import eth_udp_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int DEPTH_LOG2 = 6,
    parameter int PKT_LEN    = 64,
    parameter int GAP_CYCLES = 16
) (
    input  logic                usr_clk,
    input  logic                reset_n,
    input  logic [IN_WIDTH-1:0] in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                mode_i,
    input  logic                usr_clken_i,
    output logic                usr_start_o,
    output logic [7:0]          usr_data_o,
    output logic [15:0]         usr_data_len_o,
    output logic                busy_o,
    output logic [15:0]         pkt_count_o
);

    localparam int BPW = IN_WIDTH / 8;
`ifdef ETH_UDP_STREAMER_SEQNUM_EN
    localparam int HDR_LEN = SEQ_HDR_LEN;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int LEN       = PKT_LEN + HDR_LEN;
    localparam int PKT_WORDS = PKT_LEN / BPW;
    localparam int GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t              state_q, state_d;
    mode_t               mode_q;
    logic [15:0]         byte_idx_q, payload_idx, gap_q, pkt_count_q;
    logic [7:0]          pattern_q, fifo_byte, hdr_byte;
    logic                start_q, full, empty, consume, last_byte, in_payload, pop;
    logic [1:0]          sub;
    logic [IN_WIDTH-1:0] head;
    logic [DEPTH_LOG2:0] level;

    eth_udp_fifo #(.WIDTH(IN_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .usr_clk (usr_clk),
        .reset_n (reset_n),
        .push    (in_valid_i && !full),
        .wr_data (in_data_i),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

`ifdef ETH_UDP_STREAMER_SEQNUM_EN
    logic [15:0] seq_q;

    assign in_payload  = (byte_idx_q >= 16'(HDR_LEN));
    assign payload_idx = byte_idx_q - 16'(HDR_LEN);
    assign hdr_byte    = byte_idx_q[0] ? seq_q[7:0] : seq_q[15:8];

    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n)                 seq_q <= '0;
        else if (consume && last_byte) seq_q <= seq_q + 16'd1;
    end
`else
    assign in_payload  = 1'b1;
    assign payload_idx = byte_idx_q;
    assign hdr_byte    = 8'h00;
`endif

    assign consume   = ((state_q == ARM) || (state_q == SEND)) && usr_clken_i;
    assign last_byte = (byte_idx_q == 16'(LEN - 1));
    assign sub       = 2'(payload_idx % 16'(BPW));
    // Words leave the FIFO only once their final (least significant) byte has been taken.
    assign pop       = consume && (mode_q == MODE_FIFO) && in_payload && (sub == 2'(BPW - 1)) && !empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fifo_byte = 8'h00;
        for (int b = 0; b < BPW; b++) begin
            if (sub == 2'(BPW - 1 - b)) fifo_byte = head[b*8 +: 8];
        end
    end

    always_comb begin
        usr_data_o = fifo_byte;
        if (!in_payload)                  usr_data_o = hdr_byte;
        else if (mode_q == MODE_COUNTER)  usr_data_o = pattern_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mode_i || (level >= (DEPTH_LOG2 + 1)'(PKT_WORDS))) state_d = ARM;
            ARM:  if (usr_clken_i) state_d = SEND;
            SEND: if (usr_clken_i && last_byte) state_d = GAP;
            GAP:  if (gap_q >= 16'(GAP_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_FIFO;
            start_q     <= 1'b0;
            byte_idx_q  <= '0;
            pattern_q   <= '0;
            gap_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= (state_d == ARM);
            gap_q   <= (state_q == GAP) ? gap_q + 16'd1 : 16'd0;
            if ((state_q == IDLE) && (state_d == ARM)) mode_q <= mode_t'(mode_i);
            if (consume) begin
                byte_idx_q <= last_byte ? 16'd0 : byte_idx_q + 16'd1;
                if (in_payload && (mode_q == MODE_COUNTER)) pattern_q <= pattern_q + 8'd1;
                if (last_byte) pkt_count_q <= pkt_count_q + 16'd1;
            end
        end
    end

    assign in_ready_o     = !full;
    assign usr_start_o    = start_q;
    assign usr_data_len_o = 16'(LEN);
    assign busy_o         = (state_q != IDLE);
    assign pkt_count_o    = pkt_count_q;

endmodule
